// File: rtl/prio_encode_rr_pkg.sv
// Shared definitions for the registered priority encoder.
// Provides the mode encodings and the two-state handshake FSM encoding.
package prio_encode_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : prio_encode_rr_pkg

// File: rtl/prio_encode_rr_find.sv
// Combinational highest-set-bit finder.
// Ports:
//   d     - request vector
//   idx   - index of the highest set bit (0 when none)
//   found - at least one bit of d is set
module prio_find #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] d,
    output logic [W-1:0] idx,
    output logic         found
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (d[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule : prio_find

// File: rtl/prio_encode_rr.sv
// Registered N-way priority encoder with a valid/ready output and an
// optional round-robin mode.
// Ports:
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   d        - level request lines, bit i requests index i
//   mode     - 0 fixed priority (highest index wins), 1 round-robin
//   a        - registered winning index
//   valid    - a holds a captured winner
//   ready    - consumer accepts a when valid && ready at a clock edge
//   multi    - more than one request was set when a was captured
module prio_encode_rr
    import prio_encode_rr_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         mode,
    output logic [W-1:0] a,
    output logic         valid,
    input  logic         ready,
    output logic         multi
);

    state_t         state_q;
    state_t         state_d;
    logic           capture;
    logic [W-1:0]   p_q;
    logic [N-1:0]   mask_d;
    logic [W-1:0]   m_idx;
    logic           m_found;
    logic [W-1:0]   u_idx;
    logic           u_found;
    logic [W-1:0]   win;

    // Requests at or below the round-robin pointer.
    always_comb begin
        mask_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask_d[i] = d[i] & (W'(i) <= p_q);
        end
    end

    prio_find #(.N(N), .W(W)) u_find_masked (
        .d     (mask_d),
        .idx   (m_idx),
        .found (m_found)
    );

    prio_find #(.N(N), .W(W)) u_find_full (
        .d     (d),
        .idx   (u_idx),
        .found (u_found)
    );

    // Circular descending search from p: below-or-at p first, else wrap to the top.
    always_comb begin
        win = u_idx;
        if (mode == MODE_RR && m_found) begin
            win = m_idx;
        end
    end

    // Next state and capture strobe.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (u_found) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (u_found) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers; frozen unless a new winner is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            multi <= 1'b0;
        end else if (capture) begin
            a     <= win;
            multi <= (d & (d - N'(1))) != '0;
        end
    end

    // Round-robin pointer. A captured grant can only be followed by another
    // capture once it has been accepted, so moving p when the round-robin
    // grant is taken gives the same grant order as moving it on the accept,
    // and the capture on an accept edge still sees the pre-edge pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= W'(N - 1);
        end else if (capture && mode == MODE_RR) begin
            p_q <= (win == '0) ? W'(N - 1) : win - W'(1);
        end
    end

    assign valid = (state_q == HOLD);

endmodule : prio_encode_rr

// File: tb/tb_prio_encode_rr.sv
// Self-checking bench for prio_encode_rr: directed tables, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_prio_encode_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic       mode;
    logic       ready;
    logic [1:0] a;
    logic       valid;
    logic       multi;

    logic [7:0] d8;
    logic [2:0] a8;
    logic       valid8;
    logic       multi8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_valid, m_a, m_multi, m_p, m_mode;

    always #5 clk = ~clk;

    prio_encode_rr #(.N(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .mode  (mode),
        .a     (a),
        .valid (valid),
        .ready (ready),
        .multi (multi)
    );

    prio_encode_rr #(.N(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .d     (d8),
        .mode  (1'b1),
        .a     (a8),
        .valid (valid8),
        .ready (1'b1),
        .multi (multi8)
    );

    typedef struct {
        logic [3:0] d;
        logic       mode;
        logic       ready;
        int         exp_a;
        int         exp_valid;
        int         exp_multi;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fixed_pick(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int i = (p - k + 4) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int popcount4(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_multi = 0; m_p = 3; m_mode = 0;
    endtask

    // One clock edge of the specified behaviour, using the current inputs.
    task automatic model_edge();
        if (m_valid == 1 && ready) begin
            if (m_mode == 1) m_p = (m_a + 3) % 4;
            m_valid = 0;
        end else if (m_valid == 1) begin
            return;
        end
        if (d != 4'b0000) begin
            m_mode  = int'(mode);
            m_a     = (mode == 1'b1) ? rr_pick(d, m_p) : fixed_pick(d);
            m_multi = (popcount4(d) > 1) ? 1 : 0;
            m_valid = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, int'(valid), m_valid);
        check({tag, ".a"},     int'(a),     m_a);
        check({tag, ".multi"}, int'(multi), m_multi);
    endtask

    initial begin
        vec_t vecs[9];
        vecs[0] = '{4'b1111, 1'b0, 1'b1, 3, 1, 1};
        vecs[1] = '{4'b0100, 1'b0, 1'b1, 2, 1, 0};
        vecs[2] = '{4'b0010, 1'b0, 1'b1, 1, 1, 0};
        vecs[3] = '{4'b0001, 1'b0, 1'b1, 0, 1, 0};
        vecs[4] = '{4'b1111, 1'b1, 1'b1, 3, 1, 1};
        vecs[5] = '{4'b1111, 1'b1, 1'b1, 2, 1, 1};
        vecs[6] = '{4'b1111, 1'b1, 1'b1, 1, 1, 1};
        vecs[7] = '{4'b1111, 1'b1, 1'b1, 0, 1, 1};
        vecs[8] = '{4'b1111, 1'b1, 1'b1, 3, 1, 1};

        rst = 1'b1; d = '0; mode = 1'b0; ready = 1'b1; d8 = '0;
        model_reset();
        #12;
        check("reset.valid", int'(valid), 0);
        check("reset.a",     int'(a),     0);
        check("reset.multi", int'(multi), 0);
        rst = 1'b0;

        // Fixed-priority sequence followed by round-robin rotation.
        for (int i = 0; i < 9; i++) begin
            d = vecs[i].d; mode = vecs[i].mode; ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d.a", i),     int'(a),     vecs[i].exp_a);
            check($sformatf("vec%0d.valid", i), int'(valid), vecs[i].exp_valid);
            check($sformatf("vec%0d.multi", i), int'(multi), vecs[i].exp_multi);
        end

        // Back-pressure: a request arriving during a stall is served later.
        d = 4'b0010; mode = 1'b0; ready = 1'b1;
        step();
        check("bp.first_a", int'(a), 1);
        ready = 1'b0; d = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.stall_a",     int'(a),     1);
            check("bp.stall_valid", int'(valid), 1);
        end
        ready = 1'b1;
        step();
        check("bp.release_a", int'(a), 3);

        // Asynchronous reset in the middle of HOLD.
        d = 4'b0100; mode = 1'b0; ready = 1'b1;
        step();
        check("rst.pre_a", int'(a), 2);
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst.async_valid", int'(valid), 0);
        check("rst.async_a",     int'(a),     0);
        model_reset();
        #1 rst = 1'b0;
        mode = 1'b1; d = 4'b0011; ready = 1'b1;
        step();
        check("rst.first_rr_a",     int'(a),     1);
        check("rst.first_rr_multi", int'(multi), 1);

        // Idle, then a single request drains back to IDLE.
        d = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle.valid", int'(valid), 0);
        end
        d = 4'b0001;
        step();
        check("drain.valid", int'(valid), 1);
        check("drain.a",     int'(a),     0);
        d = '0;
        step();
        check("drain.idle_valid", int'(valid), 0);
        check("drain.keep_a",     int'(a),     0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            d     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) d = '0;
            mode  = 1'($urandom_range(0, 1));
            ready = ($urandom_range(0, 3) != 0);
            step();
            check_model("rand");
        end

        // Wide configuration: two far-apart requesters alternate.
        d8 = 8'b1000_0001;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wide.a",     int'(a8),     (i % 2 == 0) ? 7 : 0);
            check("wide.multi", int'(multi8), 1);
            check("wide.valid", int'(valid8), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prio_encode_rr
